// File: rtl/uart_tx_if.sv
// Write-side and line-side signals of the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [CW-1:0] count;
    logic          busy;
    logic          tx;

    modport master (
        output wr_en, wr_data,
        input  full, count, busy, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, count, busy, tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a byte FIFO written by the MMIO decoder.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full_q;
    logic          busy_q;
    logic          tx_q;

    logic          baud_end_c;
    logic          push_c;
    logic          pop_c;
    logic          active_nxt_c;
    logic [CW-1:0] count_nxt_c;

    // Push/pop decisions; full is registered so a write while full is dropped even alongside a pop.
    always_comb begin
        baud_end_c   = (baud_cnt == BW'(DIV - 1));
        push_c       = bus.wr_en && !full_q;
        pop_c        = (count_q != '0) && ((state == IDLE) || ((state == STOP) && baud_end_c));
        count_nxt_c  = count_q + CW'(push_c) - CW'(pop_c);
        active_nxt_c = 1'b1;
        case (state)
            IDLE:    active_nxt_c = pop_c;
            STOP:    active_nxt_c = !baud_end_c || pop_c;
            default: active_nxt_c = 1'b1;
        endcase
    end

    // FIFO storage; contents are don't-care after reset since the pointers restart.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt_c;
            full_q  <= (count_nxt_c == CW'(FIFO_DEPTH));
        end
    end

    // Frame FSM with baud counter, shift register and registered line/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= active_nxt_c || (count_nxt_c != '0);
            if (state != IDLE) begin
                baud_cnt <= baud_end_c ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    if (pop_c) begin
                        shreg <= mem[rd_ptr];
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end_c) begin
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end_c) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_end_c) begin
                        if (pop_c) begin
                            shreg <= mem[rd_ptr];
                            tx_q  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.full  = full_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.tx    = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: serial monitor decodes frames against a byte scoreboard.
module tb_uart_tx;
    localparam int unsigned DIV   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   rx_frames = 0;
    bit   mon_en = 1'b0;

    logic [7:0] sb_q[$];
    int         start_log[$];

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx #(
        .CLK_FREQ  (800),
        .BAUD      (100),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_frame, output int at);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (expect_frame) sb_q.push_back(b);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        at = cyc;
    endtask

    task automatic wait_idle(input int budget, output int at);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            wait_cycles(1);
            n++;
        end
        at = cyc;
        check("wait_idle", 32'(bus.busy), 32'(0));
    endtask

    // Serial receiver: samples each bit mid-period and compares the byte with the scoreboard head.
    initial begin : monitor
        logic [7:0] rx;
        logic       startb;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && bus.tx === 1'b0) begin
                start_log.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                startb = bus.tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rx[i] = bus.tx;
                end
                repeat (DIV) @(negedge clk);
                stopb = bus.tx;
                rx_frames++;
                check("rx_start_bit", 32'(startb), 32'(0));
                check("rx_stop_bit", 32'(stopb), 32'(1));
                check("rx_have_expected", 32'(sb_q.size() != 0), 32'(1));
                if (sb_q.size() != 0) check("rx_byte", 32'(rx), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         n0;
        int         n1;
        int         n2;
        int         t;
        bit         saw_low;
        logic [9:0] pat;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset state
        wait_cycles(3);
        check("rst_tx", 32'(bus.tx), 32'(1));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_count", 32'(bus.count), 32'(0));
        check("rst_full", 32'(bus.full), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        check("idle_tx", 32'(bus.tx), 32'(1));
        mon_en = 1'b1;

        // Test 1: single byte 0xA5, latency and bit pattern
        write_byte(8'hA5, 1'b1, n0);
        check("t1_busy_on_write", 32'(bus.busy), 32'(1));
        check("t1_count_1", 32'(bus.count), 32'(1));
        check("t1_tx_high_at_write", 32'(bus.tx), 32'(1));
        wait_cycles(1);
        check("t1_tx_low_next", 32'(bus.tx), 32'(0));
        check("t1_count_popped", 32'(bus.count), 32'(0));
        pat = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_cycles((k == 0) ? int'(DIV / 2) : int'(DIV));
            check("t1_bit", 32'(bus.tx), 32'(pat[k]));
        end
        wait_cycles(3);
        check("t1_busy_last_stop", 32'(bus.busy), 32'(1));
        wait_cycles(1);
        check("t1_busy_drop", 32'(bus.busy), 32'(0));
        check("t1_tx_idle", 32'(bus.tx), 32'(1));
        wait_cycles(4);

        // Test 2: three consecutive writes, back-to-back frames
        start_log.delete();
        write_byte(8'h00, 1'b1, n0);
        check("t2_count_first", 32'(bus.count), 32'(1));
        write_byte(8'hFF, 1'b1, n1);
        write_byte(8'h3C, 1'b1, n2);
        check("t2_count_third", 32'(bus.count), 32'(2));
        check("t2_consecutive", 32'(n2 - n0), 32'(2));
        wait_idle(4 * FRAME, t);
        check("t2_busy_span", 32'(t), 32'(n0 + 1 + 3 * FRAME));
        check("t2_count_drained", 32'(bus.count), 32'(0));
        wait_cycles(2);
        check("t2_frames", 32'(start_log.size()), 32'(3));
        if (start_log.size() == 3) begin
            check("t2_first_start", 32'(start_log[0]), 32'(n0 + 1));
            check("t2_gap_1", 32'(start_log[1] - start_log[0]), 32'(FRAME));
            check("t2_gap_2", 32'(start_log[2] - start_log[1]), 32'(FRAME));
        end

        // Test 3/4: fill FIFO while a frame is on the wire, overflow drop, write at pop while full
        start_log.delete();
        write_byte(8'h11, 1'b1, n0);
        wait_cycles(2);
        check("t3_count_empty", 32'(bus.count), 32'(0));
        write_byte(8'h21, 1'b1, t);
        write_byte(8'h22, 1'b1, t);
        write_byte(8'h23, 1'b1, t);
        check("t3_not_full_at_3", 32'(bus.full), 32'(0));
        check("t3_count_3", 32'(bus.count), 32'(3));
        write_byte(8'h24, 1'b1, t);
        check("t3_full_at_4", 32'(bus.full), 32'(1));
        check("t3_count_4", 32'(bus.count), 32'(4));
        write_byte(8'h25, 1'b0, t);
        check("t3_drop_count", 32'(bus.count), 32'(4));
        check("t3_drop_full", 32'(bus.full), 32'(1));
        while (cyc < n0 + int'(FRAME)) wait_cycles(1);
        write_byte(8'h26, 1'b0, t);
        check("t4_write_at_stop_end", 32'(t), 32'(n0 + 1 + FRAME));
        check("t4_count_3", 32'(bus.count), 32'(3));
        check("t4_full_clear", 32'(bus.full), 32'(0));
        wait_idle(6 * FRAME, t);
        wait_cycles(2);
        check("t3_frames", 32'(start_log.size()), 32'(5));
        if (start_log.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                check("t3_gap", 32'(start_log[i] - start_log[i-1]), 32'(FRAME));
            end
        end

        // Test 6: write during STOP of the previous byte
        start_log.delete();
        write_byte(8'h5A, 1'b1, n0);
        while (cyc < n0 + int'(FRAME) - 5) wait_cycles(1);
        write_byte(8'hC3, 1'b1, t);
        check("t6_tx_stop_bit", 32'(bus.tx), 32'(1));
        check("t6_busy", 32'(bus.busy), 32'(1));
        wait_idle(3 * FRAME, t);
        wait_cycles(2);
        check("t6_frames", 32'(start_log.size()), 32'(2));
        if (start_log.size() == 2) begin
            check("t6_start_spacing", 32'(start_log[1] - start_log[0]), 32'(FRAME));
        end

        // Test 5: reset in the middle of DATA of 0x81
        mon_en = 1'b0;
        write_byte(8'h81, 1'b0, n0);
        while (cyc < n0 + 30) wait_cycles(1);
        check("t5_mid_data_bit2", 32'(bus.tx), 32'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", 32'(bus.tx), 32'(1));
        check("t5_rst_busy", 32'(bus.busy), 32'(0));
        check("t5_rst_count", 32'(bus.count), 32'(0));
        check("t5_rst_full", 32'(bus.full), 32'(0));
        wait_cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wait_cycles(1);
            if (bus.tx !== 1'b1) saw_low = 1'b1;
        end
        check("t5_no_residual", 32'(saw_low), 32'(0));
        check("t5_busy_after", 32'(bus.busy), 32'(0));
        mon_en = 1'b1;

        // Final scoreboard state
        wait_cycles(4);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        check("rx_frame_total", 32'(rx_frames), 32'(11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
